sisc_ctrl_alu_br: RTL and testbench
===================================

// Module: sisc_ctrl_alu_br
// PURPOSE
//  SISC control + datapath core: multicycle control FSM (ctrl), 32-bit ALU with status flags (alu),
//  branch-target calculator (br). Sits between IR/PC/RF/status register; drives all their enables/selects.
// PARAMETERS
//  DATA_W  32  ALU operand/result width
//  ADDR_W  16  PC / branch address width
// PORTS
//  clk       in   1       clock; all state changes on rising edge
//  rst_f     in   1       reset: one clock; asynchronous, active-low
//  opcode    in   4       instr[31:28]
//  mm        in   4       instr[27:24], branch condition mask
//  stat_in   in   4       latched status {C,V,N,Z} from status register
//  rsa,rsb   in   32      register-file read data
//  imm       in   16      instr[15:0]; imm[3:0] = ALU funct for reg-reg ops
//  pc_inc    in   16      current PC output (already incremented in fetch)
//  rf_we,wb_sel,br_sel,pc_sel,ir_load,pc_write,pc_rst,rb_sel  out 1 each, control strobes
//  alu_op    out  2       00 idle, 01 reg-reg funct, 10 rsa+sext(imm), 11 rsa+sext(imm) no flags
//  alu_result out 32      ALU result (combinational)
//  stat      out  4       new flags {C,V,N,Z}
//  stat_en   out  1       status-register load enable
//  br_addr   out  16      branch target
// BEHAVIOUR
//  FSM: START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH; HALT is absorbing.
//  rst_f low: state=START0 immediately; pc_rst=1, all other strobes 0, alu_op=00. START1: pc_rst=0.
//  All outputs decoded combinationally from state+opcode; default 0. wb_sel=0 (ALU), rb_sel=0 (rt).
//  FETCH: ir_load=1, pc_write=1, pc_sel=0 (PC+1).
//  DECODE: opcode 1111 (HLT) -> next state HALT (all strobes 0 until reset). 0000 NOP: no strobes.
//   Branches: 0100 BRA abs, taken if (stat_in&mm)!=0; 0101 BRR rel, same test;
//   0110 BNE abs, taken if (stat_in&mm)==0; 0111 BNR rel, same test.
//   br_sel=1 absolute (br_addr=imm), br_sel=0 relative (br_addr=pc_inc+imm, mod 2^16 wrap).
//   Taken: pc_sel=1, pc_write=1 in DECODE only. Not taken: no strobes. br_sel driven for any branch opcode.
//  EXECUTE and WRITEBACK: alu_op=01 for opcode 0001, 10 for 0010. WRITEBACK: rf_we=1 for 0001/0010.
//  Unknown opcodes: traverse FSM with no strobes.
//  ALU (alu_op=01, funct=imm[3:0]): 0001 ADD, 0010 SUB rsa-rsb, 0011 NOT rsa, 0100 OR, 0101 AND,
//   0110 XOR, 0111 SHL rsa<<rsb[4:0], 1000 SHR logical rsa>>rsb[4:0]. Other funct: result 0, stat_en=0.
//  Flags: Z=(result==0), N=result[31]; ADD/SUB/alu_op 10: C=carry out of 33-bit sum (SUB as rsa+~rsb+1),
//   V=signed overflow; logic/shift: C=0, V=0.
//  stat_en=1 when alu_op in {01,10} with defined funct; alu_op 00/11: stat_en=0, result=rsa+sext(imm) for 11, 0 for 00.
//  Operands stable through WRITEBACK edge, so RF and status register capture identical values.
// CONFIGURATION
//  SISC_ALU_SHIFT_EN defined: funct 0111/1000 implemented as above.
//  Undefined: 0111/1000 treated as unknown funct (result 0, stat_en=0).
// TESTING
//  rst_f=0 mid-EXECUTE -> state START0 same instant, pc_rst=1, rf_we=0; release -> FETCH after 2 clocks, ir_load=1.
//  opcode 0001 funct 0001, rsa=7FFFFFFF, rsb=1 -> result 80000000, stat {C,V,N,Z}=0110, rf_we=1 only in WRITEBACK.
//  funct 0010, rsa=5, rsb=5 -> result 0, stat=1001 (C=1 no borrow, Z=1), stat_en=1.
//  BRR mm=0001, stat_in=0001, pc_inc=0010, imm=FFFE -> DECODE: pc_sel=1, pc_write=1, br_addr=000E.
//  BNE mm=0001, stat_in=0001 -> not taken, pc_write=0 in DECODE; BNE mm=0000 -> taken, br_addr=imm.
//  HLT -> HALT after DECODE; 10 further clocks: all strobes 0, no ir_load.

Source files
------------

// File: rtl/sisc_ctrl_alu_br_if.sv
// sisc_ctrl_alu_br_if: instruction fields, operands and control strobes between the SISC core and its IR/PC/RF/status registers
interface sisc_ctrl_alu_br_if #(parameter int DATA_W = 32, parameter int ADDR_W = 16);
  logic [3:0] opcode, mm, stat_in, stat;
  logic [DATA_W-1:0] rsa, rsb, alu_result;
  logic [15:0] imm;
  logic [ADDR_W-1:0] pc_inc, br_addr;
  logic [1:0] alu_op;
  logic rf_we, wb_sel, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel, stat_en;
  modport master (
    input opcode, mm, stat_in, rsa, rsb, imm, pc_inc,
    output rf_we, wb_sel, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel, alu_op, alu_result, stat, stat_en, br_addr
  );
  modport slave (
    output opcode, mm, stat_in, rsa, rsb, imm, pc_inc,
    input rf_we, wb_sel, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel, alu_op, alu_result, stat, stat_en, br_addr
  );
endinterface

// File: rtl/sisc_ctrl_alu_br.sv
// sisc_ctrl_alu_br: multicycle control FSM, 32-bit flag-setting ALU and branch-target calculator.
// Define SISC_ALU_SHIFT_EN to implement the SHL/SHR functs; otherwise they behave as undefined functs.
module sisc_ctrl_alu_br #(parameter int DATA_W = 32, parameter int ADDR_W = 16) (
  input logic clk,
  input logic rst_f,
  sisc_ctrl_alu_br_if.master bus
);
  localparam logic [2:0] START0 = 3'd0, START1 = 3'd1, FETCH = 3'd2, DECODE = 3'd3,
                         EXECUTE = 3'd4, MEM = 3'd5, WRITEBACK = 3'd6, HALT = 3'd7;
  logic [2:0] state, nxt;
  logic [1:0] op_alu;
  logic is_br, taken, is_sub, arith, valid, ovf;
  logic [DATA_W-1:0] sext, opb, res;
  logic [DATA_W:0] sum;
  always_ff @(posedge clk or negedge rst_f)
    if (!rst_f) state <= START0;
    else state <= nxt;
  always_comb
    nxt = state == START0    ? START1 :
          state == START1    ? FETCH :
          state == FETCH     ? DECODE :
          state == DECODE    ? (bus.opcode == 4'b1111 ? HALT : EXECUTE) :
          state == EXECUTE   ? MEM :
          state == MEM       ? WRITEBACK :
          state == WRITEBACK ? FETCH : HALT;
  // BNE/BNR (opcode[1]=1) branch when no masked flag is set
  assign is_br = bus.opcode[3:2] == 2'b01;
  assign taken = is_br && (bus.opcode[1] ? ~|(bus.stat_in & bus.mm) : |(bus.stat_in & bus.mm));
  assign op_alu = bus.opcode == 4'b0001 ? 2'b01 : bus.opcode == 4'b0010 ? 2'b10 : 2'b00;
  assign bus.pc_rst = state == START0;
  assign bus.ir_load = state == FETCH;
  assign bus.pc_write = state == FETCH || (state == DECODE && taken);
  assign bus.pc_sel = state == DECODE && taken;
  assign bus.br_sel = state == DECODE && is_br && !bus.opcode[0];
  assign bus.alu_op = (state == EXECUTE || state == WRITEBACK) ? op_alu : 2'b00;
  assign bus.rf_we = state == WRITEBACK && op_alu != 2'b00;
  assign bus.wb_sel = 1'b0;
  assign bus.rb_sel = 1'b0;
  assign bus.br_addr = bus.opcode[0] ? bus.pc_inc + bus.imm[ADDR_W-1:0] : bus.imm[ADDR_W-1:0];
  // one shared adder: SUB is rsa + ~rsb + 1 so the carry reads as "no borrow"
  assign sext = {{(DATA_W-16){bus.imm[15]}}, bus.imm};
  assign is_sub = bus.alu_op == 2'b01 && bus.imm[3:0] == 4'b0010;
  assign opb = bus.alu_op[1] ? sext : is_sub ? ~bus.rsb : bus.rsb;
  assign sum = {1'b0, bus.rsa} + {1'b0, opb} + {{DATA_W{1'b0}}, is_sub};
  assign ovf = bus.rsa[DATA_W-1] == opb[DATA_W-1] && sum[DATA_W-1] != bus.rsa[DATA_W-1];
  always_comb begin
    res = '0;
    valid = 1'b0;
    arith = 1'b0;
    if (bus.alu_op[1]) begin
      res = sum[DATA_W-1:0];
      valid = ~bus.alu_op[0];
      arith = 1'b1;
    end else if (bus.alu_op[0]) begin
      valid = 1'b1;
      case (bus.imm[3:0])
        4'b0001, 4'b0010: begin
          res = sum[DATA_W-1:0];
          arith = 1'b1;
        end
        4'b0011: res = ~bus.rsa;
        4'b0100: res = bus.rsa | bus.rsb;
        4'b0101: res = bus.rsa & bus.rsb;
        4'b0110: res = bus.rsa ^ bus.rsb;
`ifdef SISC_ALU_SHIFT_EN
        4'b0111: res = bus.rsa << bus.rsb[4:0];
        4'b1000: res = bus.rsa >> bus.rsb[4:0];
`endif
        default: valid = 1'b0;
      endcase
    end
  end
  assign bus.alu_result = res;
  assign bus.stat_en = valid;
  assign bus.stat = {arith & sum[DATA_W], arith & ovf, res[DATA_W-1], res == '0};
endmodule

// File: tb/tb_sisc_ctrl_alu_br.sv
// tb_sisc_ctrl_alu_br: directed checks of reset, FSM sequencing, ALU results/flags, branch decisions and halt.
module tb_sisc_ctrl_alu_br;
  logic clk = 1'b0;
  logic rst_f = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  sisc_ctrl_alu_br_if bus();
  sisc_ctrl_alu_br dut (.clk(clk), .rst_f(rst_f), .bus(bus));
  always #10 clk = ~clk;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a, b;
    logic [15:0] im;
    logic [31:0] res;
    logic [3:0] st;
    logic en;
  } alu_v_t;
  typedef struct {
    logic [3:0] op, mm, si;
    logic [15:0] pc, im;
    logic [7:0] strb;
    logic [15:0] addr;
    logic ba_chk;
  } br_v_t;
  alu_v_t av [13];
  br_v_t bv [8];
  function automatic logic [7:0] strb();
    return {bus.rf_we, bus.wb_sel, bus.br_sel, bus.pc_sel, bus.ir_load, bus.pc_write, bus.pc_rst, bus.rb_sel};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    bus.opcode = 4'h0; bus.mm = 4'h0; bus.stat_in = 4'h0;
    bus.rsa = '0; bus.rsb = '0; bus.imm = '0; bus.pc_inc = '0;
    av[0]  = '{4'h1, 32'h7FFFFFFF, 32'h00000001, 16'h0001, 32'h80000000, 4'b0110, 1'b1};
    av[1]  = '{4'h1, 32'h00000005, 32'h00000005, 16'h0002, 32'h00000000, 4'b1001, 1'b1};
    av[2]  = '{4'h1, 32'h00000003, 32'h00000005, 16'h0002, 32'hFFFFFFFE, 4'b0010, 1'b1};
    av[3]  = '{4'h1, 32'h80000000, 32'h00000001, 16'h0002, 32'h7FFFFFFF, 4'b1100, 1'b1};
    av[4]  = '{4'h1, 32'h00000000, 32'h12345678, 16'h0003, 32'hFFFFFFFF, 4'b0010, 1'b1};
    av[5]  = '{4'h1, 32'hF0F00000, 32'h00000F0F, 16'h0004, 32'hF0F00F0F, 4'b0010, 1'b1};
    av[6]  = '{4'h1, 32'hF0F0F0F0, 32'h0F0F0F0F, 16'h0005, 32'h00000000, 4'b0001, 1'b1};
    av[7]  = '{4'h1, 32'hFFFF0000, 32'h0F0F0F0F, 16'h0006, 32'hF0F00F0F, 4'b0010, 1'b1};
`ifdef SISC_ALU_SHIFT_EN
    av[8]  = '{4'h1, 32'h00000001, 32'h00000024, 16'h0007, 32'h00000010, 4'b0000, 1'b1};
    av[9]  = '{4'h1, 32'h80000000, 32'h0000001F, 16'h0008, 32'h00000001, 4'b0000, 1'b1};
`else
    av[8]  = '{4'h1, 32'h00000001, 32'h00000024, 16'h0007, 32'h00000000, 4'b0000, 1'b0};
    av[9]  = '{4'h1, 32'h80000000, 32'h0000001F, 16'h0008, 32'h00000000, 4'b0000, 1'b0};
`endif
    av[10] = '{4'h1, 32'h12345678, 32'h87654321, 16'h000F, 32'h00000000, 4'b0000, 1'b0};
    av[11] = '{4'h2, 32'h00000001, 32'h00000000, 16'hFFFE, 32'hFFFFFFFF, 4'b0010, 1'b1};
    av[12] = '{4'h2, 32'hFFFFFFFF, 32'h00000000, 16'h0001, 32'h00000000, 4'b1001, 1'b1};
    bv[0] = '{4'h5, 4'b0001, 4'b0001, 16'h0010, 16'hFFFE, 8'h14, 16'h000E, 1'b1};
    bv[1] = '{4'h6, 4'b0001, 4'b0001, 16'h0000, 16'h1234, 8'h20, 16'h1234, 1'b1};
    bv[2] = '{4'h6, 4'b0000, 4'b0001, 16'h0000, 16'h1234, 8'h34, 16'h1234, 1'b1};
    bv[3] = '{4'h4, 4'b0100, 4'b0010, 16'h0000, 16'h00AA, 8'h20, 16'h00AA, 1'b1};
    bv[4] = '{4'h7, 4'b0010, 4'b0100, 16'hFFFF, 16'h0002, 8'h14, 16'h0001, 1'b1};
    bv[5] = '{4'h4, 4'b1000, 4'b1000, 16'h0000, 16'hBEEF, 8'h34, 16'hBEEF, 1'b1};
    bv[6] = '{4'hA, 4'b1111, 4'b1111, 16'h0100, 16'h0001, 8'h00, 16'h0000, 1'b0};
    bv[7] = '{4'h0, 4'b1111, 4'b1111, 16'h0100, 16'h0001, 8'h00, 16'h0000, 1'b0};
    #1;
    chk("reset_strobes", 32'(strb()), 32'h02);
    chk("reset_alu_op", 32'(bus.alu_op), 32'h0);
    step(); rst_f = 1'b1;
    step(); chk("start1_strobes", 32'(strb()), 32'h00);
    step(); chk("fetch_strobes", 32'(strb()), 32'h0C);
    for (int i = 0; i < 13; i++) begin
      bus.opcode = av[i].op; bus.rsa = av[i].a; bus.rsb = av[i].b; bus.imm = av[i].im;
      step(); chk($sformatf("alu%0d_decode_strobes", i), 32'(strb()), 32'h00);
      step();
      chk($sformatf("alu%0d_exec_alu_op", i), 32'(bus.alu_op), av[i].op == 4'h1 ? 32'h1 : 32'h2);
      chk($sformatf("alu%0d_exec_result", i), bus.alu_result, av[i].res);
      chk($sformatf("alu%0d_exec_stat_en", i), 32'(bus.stat_en), 32'(av[i].en));
      if (av[i].en) chk($sformatf("alu%0d_exec_stat", i), 32'(bus.stat), 32'(av[i].st));
      chk($sformatf("alu%0d_exec_strobes", i), 32'(strb()), 32'h00);
      step(); chk($sformatf("alu%0d_mem_alu_op", i), 32'(bus.alu_op), 32'h0);
      chk($sformatf("alu%0d_mem_strobes", i), 32'(strb()), 32'h00);
      step(); chk($sformatf("alu%0d_wb_strobes", i), 32'(strb()), 32'h80);
      chk($sformatf("alu%0d_wb_result", i), bus.alu_result, av[i].res);
      step(); chk($sformatf("alu%0d_fetch_strobes", i), 32'(strb()), 32'h0C);
    end
    for (int i = 0; i < 8; i++) begin
      bus.opcode = bv[i].op; bus.mm = bv[i].mm; bus.stat_in = bv[i].si; bus.pc_inc = bv[i].pc; bus.imm = bv[i].im;
      step(); chk($sformatf("br%0d_decode_strobes", i), 32'(strb()), 32'(bv[i].strb));
      if (bv[i].ba_chk) chk($sformatf("br%0d_br_addr", i), 32'(bus.br_addr), 32'(bv[i].addr));
      step(); chk($sformatf("br%0d_exec_strobes", i), 32'(strb()), 32'h00);
      chk($sformatf("br%0d_exec_alu_op", i), 32'(bus.alu_op), 32'h0);
      step(); step(); chk($sformatf("br%0d_wb_strobes", i), 32'(strb()), 32'h00);
      step(); chk($sformatf("br%0d_fetch_strobes", i), 32'(strb()), 32'h0C);
    end
    bus.opcode = 4'h1; bus.imm = 16'h0001; bus.rsa = 32'h1; bus.rsb = 32'h2;
    step(); step(); chk("pre_reset_exec_alu_op", 32'(bus.alu_op), 32'h1);
    #2 rst_f = 1'b0;
    #1 chk("mid_reset_strobes", 32'(strb()), 32'h02);
    chk("mid_reset_alu_op", 32'(bus.alu_op), 32'h0);
    step(); rst_f = 1'b1;
    step(); chk("rel_start1_strobes", 32'(strb()), 32'h00);
    step(); chk("rel_fetch_strobes", 32'(strb()), 32'h0C);
    bus.opcode = 4'hF;
    step(); chk("hlt_decode_strobes", 32'(strb()), 32'h00);
    for (int i = 0; i < 11; i++) begin
      step();
      chk($sformatf("halt%0d_strobes", i), 32'(strb()), 32'h00);
      chk($sformatf("halt%0d_alu_op", i), 32'(bus.alu_op), 32'h0);
    end
    rst_f = 1'b0;
    #1 chk("halt_reset_strobes", 32'(strb()), 32'h02);
    step(); rst_f = 1'b1;
    step(); step(); chk("halt_rel_fetch_strobes", 32'(strb()), 32'h0C);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
